// File: rtl/step_ctrl_pkg.sv
// Shared types and helpers for the single-step / free-run core clock-enable controller.
package step_ctrl_pkg;

  typedef enum logic [2:0] {HALT, STEP, HOLD, REPEAT, RUN} step_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector on a debounced level; prev resets high so a button held through reset is ignored.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/step_ctrl.sv
// Core clock-enable controller: single step, auto-repeat on long press, free-run toggle, step counter.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int RUN_DIV       = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_step,
  input  logic             btn_mode,
  output logic             cpu_en,
  output logic             running,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int CW = $clog2(max3(HOLD_CYCLES, REPEAT_CYCLES, RUN_DIV) + 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST    = CW'(RUN_DIV - 1);

  step_state_t   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] div, div_nx;
  logic          en_nx;
  logic          step_rise, mode_rise;

  rise_detect u_step_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_step),
    .pulse (step_rise)
  );

  rise_detect u_mode_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_mode),
    .pulse (mode_rise)
  );

  // Mode press outranks everything outside RUN, including a coincident step press.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    div_nx   = div;
    en_nx    = 1'b0;
    if (state != RUN && mode_rise) begin
      state_nx = RUN;
      div_nx   = '0;
      en_nx    = (RUN_DIV == 1);
    end else begin
      case (state)
        HALT: begin
          if (step_rise) begin
            state_nx = STEP;
            en_nx    = 1'b1;
          end
        end
        STEP: begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end
        HOLD: begin
          if (!btn_step) begin
            state_nx = HALT;
          end else if (cnt == HOLD_LAST) begin
            state_nx = REPEAT;
            cnt_nx   = '0;
            en_nx    = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!btn_step) begin
            state_nx = HALT;
          end else if (cnt == REPEAT_LAST) begin
            cnt_nx = '0;
            en_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        RUN: begin
          if (mode_rise) begin
            state_nx = HALT;
          end else if (div == RUN_LAST) begin
            div_nx = '0;
            en_nx  = 1'b1;
          end else begin
            div_nx = div + 1'b1;
          end
        end
        default: state_nx = HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HALT;
      cnt      <= '0;
      div      <= '0;
      cpu_en   <= 1'b0;
      running  <= 1'b0;
      step_cnt <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      div      <= div_nx;
      cpu_en   <= en_nx;
      running  <= (state_nx == RUN);
      step_cnt <= step_cnt + CNT_W'(en_nx);
    end
  end

endmodule
